// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: widths,
// FSM state encoding and the layout of one queued request.
package dm_pkg;

  localparam int DM_DATA_W = 8;
  localparam int DM_ADDR_W = 8;

  // Sequencer states; encoding is fixed so it reads the same in a waveform.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT_S = 2'd1,
    WR_HOLD_S = 2'd2,
    WR_REL    = 2'd3
  } dm_state_e;

  // One queued request as it sits in the FIFO.
  typedef struct packed {
    logic                 we;
    logic [DM_ADDR_W-1:0] addr;
    logic [DM_DATA_W-1:0] wdata;
  } dm_req_t;

  localparam int DM_REQ_W = $bits(dm_req_t);

endpackage

// File: rtl/dm_req_fifo.sv
// Two-entry request FIFO with synchronous reset and full/empty flags.
// Pushes while full and pops while empty are ignored, so callers can
// drive push/pop straight from a handshake without extra gating.
module dm_req_fifo
  import dm_pkg::*;
#(
  parameter int WIDTH = DM_REQ_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: an entry is only read after being written.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (do_push && (wr_ptr_q == 1'(gi))) mem_q[gi] <= data_i;
    end
  end

  assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/dm_access_ctrl.sv
// Clocked initiator for an asynchronous data memory. Requests are queued
// in a 2-entry FIFO and sequenced one at a time onto MemRead/MemWrite/ABUS/DIN,
// each held long enough to cover the memory's settle and commit delays.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int DATA_W  = DM_DATA_W,
  parameter int ADDR_W  = DM_ADDR_W,
  parameter int RD_WAIT = 2,
  parameter int WR_HOLD = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_RDATA,
  output logic              BUSY,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] ABUS,
  output logic [DATA_W-1:0] DIN,
  input  logic [DATA_W-1:0] DATABUS
);

  localparam int REQ_W   = 1 + ADDR_W + DATA_W;
  localparam int CNT_MAX = (RD_WAIT > WR_HOLD) ? RD_WAIT : WR_HOLD;
  // The counter only ever holds values up to CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  dm_state_e         state_q, state_d;

  logic [REQ_W-1:0]  fifo_wdata;
  logic [REQ_W-1:0]  fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] abus_q, abus_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign fifo_wdata = {REQ_WE, REQ_ADDR, REQ_WDATA};
  assign {head_we, head_addr, head_wdata} = fifo_rdata;

  // The head is consumed only when the sequencer is free to start it.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  dm_req_fifo #(
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (REQ_VALID),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one access at a time, stores get a release cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = head_we ? WR_HOLD_S : RD_WAIT_S;
      end
      RD_WAIT_S: begin
        if (cnt_q == '0) state_d = IDLE;
      end
      WR_HOLD_S: begin
        if (cnt_q == '0) state_d = WR_REL;
      end
      WR_REL: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values. ABUS/DIN are only reloaded on a pop, so they
  // stay frozen through the whole strobe window and the release cycle.
  always_comb begin
    cnt_d       = cnt_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    abus_d      = abus_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          abus_d = head_addr;
          din_d  = head_wdata;
          if (head_we) begin
            mem_write_d = 1'b1;
            cnt_d       = CNT_W'(WR_HOLD - 1);
          end else begin
            mem_read_d = 1'b1;
            cnt_d      = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      RD_WAIT_S: begin
        if (cnt_q == '0) begin
          rsp_rdata_d = DATABUS;
          rsp_valid_d = 1'b1;
          mem_read_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HOLD_S: begin
        if (cnt_q == '0) mem_write_d = 1'b0;
        else             cnt_d       = cnt_q - 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output and counter registers; reset drops the strobes on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q       <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      abus_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      abus_q      <= abus_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Ready and busy are decoded directly from registered state.
  assign REQ_READY = !fifo_full;
  assign BUSY      = !fifo_empty || (state_q != IDLE);

  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign MemRead   = mem_read_q;
  assign MemWrite  = mem_write_q;
  assign ABUS      = abus_q;
  assign DIN       = din_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl with a behavioural async memory.
// Load results are predicted from a reference memory at request time and
// queued; every RSP_VALID pops and compares the oldest expectation.
module tb_dm_access_ctrl;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int RD_WAIT = 2;
  localparam int WR_HOLD = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              REQ_VALID = 1'b0;
  logic              REQ_READY;
  logic              REQ_WE = 1'b0;
  logic [ADDR_W-1:0] REQ_ADDR = '0;
  logic [DATA_W-1:0] REQ_WDATA = '0;
  logic              RSP_VALID;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              BUSY;
  logic              MemRead;
  logic              MemWrite;
  logic [ADDR_W-1:0] ABUS;
  logic [DATA_W-1:0] DIN;
  logic [DATA_W-1:0] DATABUS;

  dm_access_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RD_WAIT (RD_WAIT),
    .WR_HOLD (WR_HOLD)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WE    (REQ_WE),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .BUSY      (BUSY),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ABUS      (ABUS),
    .DIN       (DIN),
    .DATABUS   (DATABUS)
  );

  always #5 CLK = ~CLK;

  // Async memory model: data is valid one cycle after MemRead rises (garbage
  // before), and a write commits after MemWrite has been held for 3 edges.
  logic [DATA_W-1:0] mem [0:255] = '{default: 8'h00};
  int wr_age = 0;
  int rd_age = 0;

  always @(posedge CLK) begin
    if (MemWrite && wr_age == 2) mem[ABUS] <= DIN;
    wr_age <= MemWrite ? wr_age + 1 : 0;
    rd_age <= MemRead ? rd_age + 1 : 0;
  end

  always_comb DATABUS = (MemRead && rd_age >= 1) ? mem[ABUS] : 8'hEE;

  // Bench state
  int                n_checks = 0;
  int                n_pass   = 0;
  int                cyc      = 0;
  int                rsp_seen = 0;
  int                acc_cyc  = 0;
  logic [ADDR_W-1:0] acc_abus;
  logic              acc_memread;
  logic [DATA_W-1:0] ref_mem [0:255] = '{default: 8'h00};
  logic [DATA_W-1:0] exp_q [$];
  logic              mw_prev  = 1'b0;
  logic              rsp_prev = 1'b0;
  int                mw_len   = 0;
  logic [ADDR_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_d;

  // Advance to the next falling edge and run the always-on monitors there.
  task automatic tick();
    logic [DATA_W-1:0] e;
    @(negedge CLK);
    cyc++;
    if (RST) begin
      mw_prev  = 1'b0;
      rsp_prev = 1'b0;
      mw_len   = 0;
    end else begin
      n_checks++;
      if (MemRead && MemWrite)
        $display("FAIL strobe_excl cyc=%0d MemRead=%b MemWrite=%b want not both 1", cyc, MemRead, MemWrite);
      else n_pass++;
      if (RSP_VALID) begin
        rsp_seen++;
        n_checks++;
        if (rsp_prev) $display("FAIL rsp_pulse cyc=%0d RSP_VALID high 2 cycles running, want 1-cycle pulse", cyc);
        else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rsp_unexpected cyc=%0d got rdata=%h want no response", cyc, RSP_RDATA);
        end else begin
          e = exp_q.pop_front();
          if (RSP_RDATA !== e) $display("FAIL rsp_data cyc=%0d got=%h want=%h", cyc, RSP_RDATA, e);
          else begin
            n_pass++;
            $display("rsp  cyc=%0d rdata=%h", cyc, RSP_RDATA);
          end
        end
      end
      rsp_prev = RSP_VALID;
      // ABUS/DIN frozen across the MemWrite window plus one release cycle.
      if (MemWrite && !mw_prev) begin
        lat_a  = ABUS;
        lat_d  = DIN;
        mw_len = 1;
      end else if (MemWrite || mw_prev) begin
        n_checks++;
        if (ABUS !== lat_a || DIN !== lat_d)
          $display("FAIL wr_stable cyc=%0d got ABUS=%h DIN=%h want ABUS=%h DIN=%h", cyc, ABUS, DIN, lat_a, lat_d);
        else n_pass++;
        if (MemWrite) mw_len++;
        else begin
          n_checks++;
          if (mw_len != WR_HOLD) $display("FAIL wr_len cyc=%0d got=%0d want=%0d", cyc, mw_len, WR_HOLD);
          else n_pass++;
        end
      end
      mw_prev = MemWrite;
    end
  endtask

  // Present one request and wait (bounded) for its handshake.
  task automatic send(input logic we, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, output int stall);
    int w;
    REQ_VALID = 1'b1;
    REQ_WE    = we;
    REQ_ADDR  = a;
    REQ_WDATA = d;
    w = 0;
    while (!REQ_READY && w < 50) begin
      tick();
      w++;
    end
    stall = w;
    if (!REQ_READY) begin
      n_checks++;
      $display("FAIL send_timeout addr=%h REQ_READY=%b want 1 within 50 cycles", a, REQ_READY);
    end else begin
      acc_abus    = ABUS;
      acc_memread = MemRead;
      if (we) ref_mem[a] = d;
      else    exp_q.push_back(ref_mem[a]);
      $display("req  cyc=%0d we=%b addr=%h wdata=%h stall=%0d", cyc, we, a, d, w);
      tick();
      acc_cyc = cyc;
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (BUSY && w < 200) begin
      tick();
      w++;
    end
    if (BUSY) begin
      n_checks++;
      $display("FAIL drain_timeout BUSY=%b want 0 within 200 cycles", BUSY);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++; if (REQ_READY !== 1'b1) $display("FAIL rst_ready got=%b want=1", REQ_READY); else n_pass++;
    n_checks++; if (RSP_VALID !== 1'b0) $display("FAIL rst_rsp_valid got=%b want=0", RSP_VALID); else n_pass++;
    n_checks++; if (RSP_RDATA !== 8'h00) $display("FAIL rst_rsp_rdata got=%h want=00", RSP_RDATA); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL rst_busy got=%b want=0", BUSY); else n_pass++;
    n_checks++; if (MemRead !== 1'b0) $display("FAIL rst_memread got=%b want=0", MemRead); else n_pass++;
    n_checks++; if (MemWrite !== 1'b0) $display("FAIL rst_memwrite got=%b want=0", MemWrite); else n_pass++;
    n_checks++; if (ABUS !== 8'h00) $display("FAIL rst_abus got=%h want=00", ABUS); else n_pass++;
    n_checks++; if (DIN !== 8'h00) $display("FAIL rst_din got=%h want=00", DIN); else n_pass++;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    int st;
    send(1'b1, 8'h3C, 8'hA5, st);
    send(1'b0, 8'h3C, 8'h00, st);
    drain();
  endtask

  task automatic test_unwritten();
    int st;
    send(1'b0, 8'hFF, 8'h00, st);
    drain();
  endtask

  // Latencies counted in falling edges, the one right after the handshake edge being 1.
  task automatic test_latency();
    int st, w, lat;
    send(1'b0, 8'h3C, 8'h00, st);
    w = 0;
    while (!RSP_VALID && w < 50) begin
      tick();
      w++;
    end
    lat = cyc - acc_cyc + 1;
    n_checks++;
    if (!RSP_VALID || lat != RD_WAIT + 2) $display("FAIL load_latency got=%0d want=%0d", lat, RD_WAIT + 2);
    else n_pass++;
    drain();
    send(1'b1, 8'h50, 8'h5A, st);
    w = 0;
    while (BUSY && w < 50) begin
      tick();
      w++;
    end
    lat = cyc - acc_cyc + 1;
    n_checks++;
    if (BUSY || lat != WR_HOLD + 3) $display("FAIL store_latency got=%0d want=%0d", lat, WR_HOLD + 3);
    else n_pass++;
    drain();
  endtask

  // A store occupies the sequencer; A and B fill the queue, C must stall
  // until A has been popped.
  task automatic test_queue_full();
    int st_x, st_a, st_b, st_c;
    send(1'b1, 8'h60, 8'h66, st_x);
    send(1'b0, 8'h3C, 8'h00, st_a);
    send(1'b1, 8'h40, 8'h77, st_b);
    send(1'b0, 8'h40, 8'h00, st_c);
    n_checks++;
    if (st_a != 0 || st_b != 0) $display("FAIL qfull_ab_stall got=%0d/%0d want=0/0", st_a, st_b);
    else n_pass++;
    n_checks++;
    if (st_c != WR_HOLD + 1) $display("FAIL qfull_c_stall got=%0d want=%0d", st_c, WR_HOLD + 1);
    else n_pass++;
    n_checks++;
    if (acc_memread !== 1'b1 || acc_abus !== 8'h3C)
      $display("FAIL qfull_c_after_pop got MemRead=%b ABUS=%h want 1/3c", acc_memread, acc_abus);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    int st;
    send(1'b1, 8'h10, 8'h11, st);
    send(1'b1, 8'h11, 8'h22, st);
    send(1'b0, 8'h10, 8'h00, st);
    send(1'b0, 8'h11, 8'h00, st);
    drain();
  endtask

  task automatic test_reset_mid_load();
    int st, r0;
    send(1'b0, 8'h3C, 8'h00, st);
    tick();
    n_checks++;
    if (MemRead !== 1'b1) $display("FAIL midrst_pre got MemRead=%b want=1", MemRead);
    else n_pass++;
    RST = 1'b1;
    exp_q.delete();
    tick();
    n_checks++; if (MemRead !== 1'b0) $display("FAIL midrst_memread got=%b want=0", MemRead); else n_pass++;
    n_checks++; if (RSP_VALID !== 1'b0) $display("FAIL midrst_rsp_valid got=%b want=0", RSP_VALID); else n_pass++;
    n_checks++; if (REQ_READY !== 1'b1) $display("FAIL midrst_ready got=%b want=1", REQ_READY); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL midrst_busy got=%b want=0", BUSY); else n_pass++;
    RST = 1'b0;
    r0 = rsp_seen;
    repeat (8) tick();
    n_checks++;
    if (rsp_seen != r0) $display("FAIL midrst_no_rsp got=%0d responses want=0", rsp_seen - r0);
    else n_pass++;
    // Recovery: normal traffic resumes with memory contents intact.
    send(1'b0, 8'h10, 8'h00, st);
    drain();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_unwritten();
    test_latency();
    test_queue_full();
    test_back_to_back();
    test_reset_mid_load();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d pending want=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
